conv_filter_scheduler: RTL and testbench

- Sequences K filter passes over one shared single-filter convolution engine, time-multiplexing it instead of instantiating K engines.
- Selects the active filter slice, pulses the engine start, waits for engine completion, then commits the result to the output bank slot for that filter.
- Sits between the layer-level host control (start/done) and the single-filter conv datapath plus its filter mux and result bank.

---
 rtl/conv_filter_scheduler_pkg.sv | 20 ++
 rtl/conv_pass_timer.sv | 35 +++
 rtl/conv_filter_scheduler.sv | 131 +++++++++++++
 tb/tb_conv_filter_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/conv_filter_scheduler_pkg.sv
// Shared conv-layer definitions: FSM state codes,
// default pass timeout and a clog2 helper for widths.
package conv_filter_scheduler_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ISSUE  = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_STORE  = 3'd3;
   localparam logic [2:0] ST_FINISH = 3'd4;

   localparam int DEF_TIMEOUT = 4096;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/conv_pass_timer.sv
// Pass watchdog: TW-bit up-counter with clear, load, enable.
// Ports: clk, rst_n, clr, ld/ld_val, en; expired at TIMEOUT-1.
module conv_pass_timer
   import conv_filter_scheduler_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int TW      = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          ld,
   input  logic [TW-1:0] ld_val,
   input  logic          en,
   output logic          expired
);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)      cnt_d = '0;
      else if (ld)  cnt_d = ld_val;
      else if (en)  cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/conv_filter_scheduler.sv
// Runs up to K filter passes on one shared conv engine.
// Ports: host start/abort/busy/done, engine start/done, bank write.
module conv_filter_scheduler
   import conv_filter_scheduler_pkg::*;
#(
   parameter int K       = 2,
   parameter int KW      = 2,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int TW      = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [KW-1:0] num_filters,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          timeout_err,
   output logic [KW-1:0] filt_sel,
   output logic          eng_start,
   input  logic          eng_done,
   output logic          res_we,
   output logic [KW-1:0] res_addr,
   output logic [KW-1:0] pass_cnt
);

   localparam logic [KW-1:0] K_W = KW'(K);

   logic [2:0]    state_q, state_d;
   logic [KW-1:0] n_q, n_d;
   logic [KW-1:0] filt_q, filt_d;
   logic [KW-1:0] pass_q, pass_d;
   logic          err_q, err_d;
   logic          tmr_clr, tmr_en, tmr_exp;
   logic [KW-1:0] n_in;

   // oversized requests silently run K passes
   assign n_in = (num_filters > K_W) ? K_W : num_filters;

   conv_pass_timer #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_timer (
      .clk     (clk),
      .rst_n   (reset),
      .clr     (tmr_clr),
      .ld      (1'b0),
      .ld_val  ('0),
      .en      (tmr_en),
      .expired (tmr_exp)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      filt_d  = filt_q;
      pass_d  = pass_q;
      err_d   = err_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               n_d     = n_in;
               err_d   = 1'b0;
               pass_d  = '0;
               filt_d  = '0;
               state_d = (n_in == '0) ? ST_FINISH : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tmr_clr = 1'b1;
            state_d = abort ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            // priority: abort, then engine done, then timeout
            if (abort) begin
               state_d = ST_IDLE;
            end else if (eng_done) begin
               state_d = ST_STORE;
            end else if (tmr_exp) begin
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_STORE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               pass_d = pass_q + KW'(1);
               if (filt_q == n_q - KW'(1)) begin
                  state_d = ST_FINISH;
               end else begin
                  filt_d  = filt_q + KW'(1);
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         filt_q  <= '0;
         pass_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         filt_q  <= filt_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_FINISH);
   assign eng_start   = (state_q == ST_ISSUE);
   assign res_we      = (state_q == ST_STORE);
   assign res_addr    = filt_q;
   assign filt_sel    = filt_q;
   assign pass_cnt    = pass_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Randomised + directed bench for conv_filter_scheduler.
// Engine model and expected schedule live in the bench.
module tb_conv_filter_scheduler;
   import conv_filter_scheduler_pkg::*;

   localparam int K_T  = 4;
   localparam int KW_T = clog2(K_T + 1);
   localparam int TO_T = 16;
   localparam int TW_T = clog2(TO_T);

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [KW_T-1:0] num_filters = '0;
   logic            abort = 1'b0;
   logic            busy, done, timeout_err;
   logic [KW_T-1:0] filt_sel, res_addr, pass_cnt;
   logic            eng_start, res_we;
   logic            eng_done = 1'b0;

   int errors = 0;
   int checks = 0;

   conv_filter_scheduler #(
      .K (K_T), .KW (KW_T), .TIMEOUT (TO_T), .TW (TW_T)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_filters (num_filters),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .filt_sel    (filt_sel),
      .eng_start   (eng_start),
      .eng_done    (eng_done),
      .res_we      (res_we),
      .res_addr    (res_addr),
      .pass_cnt    (pass_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cmpq(input string tag, input int obs[$],
                       input int exp[$]);
      chk({tag, "_n"}, obs.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         if (i < obs.size()) chk($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
      end
   endtask

   // Runs one layer starting at the current negedge (cycle 0).
   // lat=0 means the engine never answers; ab<0 means no abort.
   task automatic run(input int nf, input int lat, input int ab,
                      input bit noise);
      int n, dcyc, endb, due, bn, bl, s;
      int es[$], we[$], wa[$], dn[$];
      int xes[$], xwe[$], xwa[$], xdn[$];
      logic err1, errd;
      n    = (nf > K_T) ? K_T : nf;
      if (n == 0)        dcyc = 1;
      else if (lat == 0) dcyc = 2 + TO_T;
      else               dcyc = 1 + n * (lat + 2);
      endb = (ab >= 0) ? ab : dcyc;
      due  = -1; bn = 0; bl = -1;
      err1 = 1'bx; errd = 1'bx;
      for (int rel = 0; rel <= endb + 4; rel++) begin
         if (rel > 0) begin
            if (eng_start) begin
               es.push_back(rel);
               if (lat > 0) due = rel + lat;
            end
            if (res_we) begin
               we.push_back(rel);
               wa.push_back(int'(res_addr));
            end
            if (done) dn.push_back(rel);
            if (busy) begin bn++; bl = rel; end
            if (rel == 1)    err1 = timeout_err;
            if (rel == dcyc) errd = timeout_err;
         end
         start       = (rel == 0) ||
                       (noise && rel <= endb && ($urandom % 2 == 1));
         num_filters = (rel == 0 || !noise) ? KW_T'(nf) :
                       KW_T'($urandom);
         abort       = (rel == ab) ||
                       (noise && rel > endb && ($urandom % 3 == 0));
         eng_done    = (rel == due) ||
                       (noise && rel > endb && ($urandom % 2 == 1));
         @(negedge clk);
      end
      start = 1'b0; abort = 1'b0; eng_done = 1'b0;
      if (lat == 0) begin
         if (n > 0) xes.push_back(1);
      end else begin
         for (int p = 0; p < n; p++) begin
            s = 1 + p * (lat + 2);
            if (s <= endb) xes.push_back(s);
            if (s + lat + 1 <= endb) begin
               xwe.push_back(s + lat + 1);
               xwa.push_back(p);
            end
         end
      end
      if (ab < 0) xdn.push_back(dcyc);
      cmpq("eng_start_cyc", es, xes);
      cmpq("res_we_cyc", we, xwe);
      cmpq("res_addr", wa, xwa);
      cmpq("done_cyc", dn, xdn);
      chk("busy_cycles", bn, endb);
      chk("busy_last", bl, endb);
      chk("err_after_start", int'(err1), 0);
      if (ab < 0)
         chk("err_at_done", int'(errd), (lat == 0 && n > 0) ? 1 : 0);
      chk("pass_cnt", int'(pass_cnt), xwe.size());
      chk("timeout_err", int'(timeout_err),
          (ab < 0 && lat == 0 && n > 0) ? 1 : 0);
   endtask

   initial begin
      int nf, lat, ab, n;
      #2;
      chk("rst_outputs", int'({busy, done, eng_start, res_we, timeout_err,
          filt_sel, res_addr, pass_cnt}), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      run(3, 5, -1, 1'b0);
      run(0, 5, -1, 1'b1);
      run(7, 5, -1, 1'b1);
      run(2, 0, -1, 1'b0);
      run(1, 3, -1, 1'b0);
      run(2, 5, 6, 1'b0);
      run(2, 5, -1, 1'b0);

      // async reset in WAIT of the second pass
      num_filters = 3'd2;
      start = 1'b1;
      for (int rel = 1; rel <= 10; rel++) begin
         @(negedge clk);
         start    = 1'b0;
         eng_done = (rel == 6);
      end
      eng_done = 1'b0;
      chk("pre_rst_busy", int'(busy), 1);
      chk("pre_rst_pass", int'(pass_cnt), 1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst", int'({busy, done, eng_start, res_we, timeout_err,
          filt_sel, res_addr, pass_cnt}), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run(4, 2, -1, 1'b1);

      for (int it = 0; it < 8; it++) begin
         nf  = int'($urandom_range(7, 0));
         lat = int'($urandom_range(6, 1));
         n   = (nf > K_T) ? K_T : nf;
         ab  = -1;
         if (n > 0 && ($urandom % 3 == 0))
            ab = 2 + int'($urandom_range(n - 1, 0)) * (lat + 2) +
                 int'($urandom_range(lat - 1, 0));
         run(nf, lat, ab, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
